speed_step_driver: RTL and testbench

Drives the `enable`/`mode` inputs of a WIDTH-bit up/down counter so that its value slews, one count at a time, to a requested target at a fixed rate. It takes the counter's present value as feedback and is the command side of the counter interface. In the cruise-control datapath it sits between the set-speed logic and the speed counter.

---
 rtl/speed_step_driver.sv | 92 +++++++++
 tb/tb_speed_step_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/speed_step_driver.sv
// Rate-limited slew controller: steps an external up/down counter toward a latched target,
// issuing one enable pulse every STEP_DIV cycles until the counter equals the target.
`timescale 1ns/1ps
module speed_step_driver #(
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] target,
    input  logic             load,
    input  logic             cancel,
    input  logic [WIDTH-1:0] count,
    output logic             enable,
    output logic             mode,
    output logic             busy,
    output logic             done
);

    localparam int unsigned HW = $clog2(STEP_DIV);
    localparam logic [HW-1:0] HoldInit = HW'(STEP_DIV - 2);
    localparam logic [HW-1:0] HoldLast = HW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StStep,
        StHold,
        StDone
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] tgt_q;
    logic             mode_q;
    logic [HW-1:0]    hcnt;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state  <= StIdle;
            tgt_q  <= '0;
            mode_q <= 1'b0;
            hcnt   <= '0;
        end else if (cancel) begin
            // Cancel beats a simultaneous load, so the target is left untouched.
            state <= StIdle;
        end else begin
            if (load) begin
                tgt_q <= target;
            end
            case (state)
                StIdle: begin
                    if (load) begin
                        state <= StCompare;
                    end
                end
                StCompare: begin
                    if (load) begin
                        state <= StCompare;
                    end else if (count == tgt_q) begin
                        state <= StDone;
                    end else begin
                        mode_q <= (count < tgt_q);
                        state  <= StStep;
                    end
                end
                StStep: begin
                    hcnt  <= HoldInit;
                    state <= StHold;
                end
                StHold: begin
                    // A load here only updates tgt_q; the hold runs out to keep the step rate.
                    hcnt <= hcnt - HoldLast;
                    if (hcnt == HoldLast) begin
                        state <= StCompare;
                    end
                end
                StDone: begin
                    state <= load ? StCompare : StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign enable = (state == StStep);
    assign done   = (state == StDone);
    assign busy   = (state != StIdle);
    assign mode   = mode_q;

endmodule

// File: tb/tb_speed_step_driver.sv
// Directed bench for speed_step_driver with a behavioural up/down counter in the loop and
// scoreboard queues holding the expected enable/done sample indices.
`timescale 1ns/1ps
module tb_speed_step_driver;

    localparam int WIDTH    = 7;
    localparam int STEP_DIV = 4;

    typedef struct {
        int   c;
        logic m;
    } en_t;

    logic             clk        = 1'b0;
    logic             clear      = 1'b1;
    logic             load       = 1'b0;
    logic             cancel     = 1'b0;
    logic [WIDTH-1:0] target     = '0;
    logic [WIDTH-1:0] count      = '0;
    logic [WIDTH-1:0] preset_val = '0;
    logic             preset_en  = 1'b0;
    logic             enable, mode, busy, done;

    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic prev_done   = 1'b0;
    en_t  en_q[$];
    int   dq[$];

    speed_step_driver #(
        .WIDTH   (WIDTH),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .target(target),
        .load  (load),
        .cancel(cancel),
        .count (count),
        .enable(enable),
        .mode  (mode),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural speed counter driven by the DUT's enable/mode.
    always @(posedge clk) begin
        if (preset_en) count <= preset_val;
        else if (enable) count <= mode ? count + 7'd1 : count - 7'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d (sample %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock; outputs are sampled on the falling edge.
    task automatic tick();
        en_t e;
        @(posedge clk);
        @(negedge clk);
        if (prev_done) chk("busy_after_done", {31'b0, busy}, 32'd0);
        prev_done = done;
        if (enable) begin
            if (en_q.size() > 0) begin
                e = en_q.pop_front();
                chk("enable_cycle", cyc, e.c);
                chk("enable_mode", {31'b0, mode}, {31'b0, e.m});
            end else begin
                chk("enable_unexpected", cyc, -1);
            end
        end
        if (done) begin
            if (dq.size() > 0) chk("done_cycle", cyc, dq.pop_front());
            else chk("done_unexpected", cyc, -1);
        end
    endtask

    task automatic preset(input logic [WIDTH-1:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        tick();
        preset_en  = 1'b0;
    endtask

    task automatic push_slew(input int l, input int d, input logic m);
        for (int k = 0; k < d; k++) en_q.push_back('{c: l + 1 + STEP_DIV * k, m: m});
        dq.push_back(l + 1 + STEP_DIV * d);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] t);
        target = t;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        chk("busy_rise", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        do begin
            tick();
            i++;
        end while (busy && i < budget);
        chk("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_enables_left"}, en_q.size(), 0);
        chk({tag, "_dones_left"}, dq.size(), 0);
    endtask

    initial begin
        int l;
        int l2;

        // Reset asserted mid-cycle: outputs clear without waiting for a clock edge.
        @(posedge clk);
        #2 clear = 1'b0;
        #1;
        chk("rst_enable", {31'b0, enable}, 32'd0);
        chk("rst_mode", {31'b0, mode}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        clear = 1'b1;
        repeat (6) tick();
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Up slew 10 -> 13.
        preset(7'd10);
        l = cyc + 1;
        push_slew(l, 3, 1'b1);
        do_load(7'd13);
        wait_idle(40);
        chk("up_count", {25'b0, count}, 32'd13);
        chk("up_mode_held", {31'b0, mode}, 32'd1);
        chk_drained("up");

        // Down slew 20 -> 17.
        preset(7'd20);
        l = cyc + 1;
        push_slew(l, 3, 1'b0);
        do_load(7'd17);
        wait_idle(40);
        chk("down_count", {25'b0, count}, 32'd17);
        chk("down_mode_held", {31'b0, mode}, 32'd0);
        chk_drained("down");

        // Already at target.
        preset(7'd5);
        l = cyc + 1;
        push_slew(l, 0, 1'b0);
        do_load(7'd5);
        wait_idle(10);
        chk("eq_count", {25'b0, count}, 32'd5);
        chk_drained("eq");

        // Retarget 0 -> 10 redirected to 1 while holding at count 3.
        preset(7'd0);
        l = cyc + 1;
        for (int k = 0; k < 3; k++) en_q.push_back('{c: l + 1 + STEP_DIV * k, m: 1'b1});
        do_load(7'd10);
        while (cyc < l + 10) tick();
        chk("rt_mid_count", {25'b0, count}, 32'd3);
        l2 = cyc + 1;
        en_q.push_back('{c: l2 + 2, m: 1'b0});
        en_q.push_back('{c: l2 + 2 + STEP_DIV, m: 1'b0});
        dq.push_back(l2 + 2 + 2 * STEP_DIV);
        do_load(7'd1);
        wait_idle(60);
        chk("rt_count", {25'b0, count}, 32'd1);
        chk_drained("rt");

        // Cancel together with load during a STEP cycle.
        preset(7'd0);
        l = cyc + 1;
        en_q.push_back('{c: l + 1, m: 1'b1});
        en_q.push_back('{c: l + 1 + STEP_DIV, m: 1'b1});
        do_load(7'd10);
        while (cyc < l + 1 + STEP_DIV) tick();
        cancel = 1'b1;
        load   = 1'b1;
        target = 7'd50;
        tick();
        cancel = 1'b0;
        load   = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        repeat (12) tick();
        chk("abort_count", {25'b0, count}, 32'd2);
        chk("abort_tgt", {25'b0, dut.tgt_q}, 32'd10);
        chk_drained("abort");

        // Reset while enable is high: enable must fall immediately.
        preset(7'd0);
        l = cyc + 1;
        en_q.push_back('{c: l + 1, m: 1'b1});
        do_load(7'd10);
        tick();
        chk("pre_clr_enable", {31'b0, enable}, 32'd1);
        #1 clear = 1'b0;
        #1;
        chk("clr_enable", {31'b0, enable}, 32'd0);
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_mode", {31'b0, mode}, 32'd0);
        #1 clear = 1'b1;
        repeat (8) tick();
        chk("clr_count", {25'b0, count}, 32'd0);
        chk_drained("clr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at sample %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
